// File: rtl/down_counter_timer.sv
// -----------------------------------------------------------------------------
// down_counter_timer
//   Loadable, programmable down-counter/timer. A count value is loaded through
//   a valid/ready handshake, counting is started explicitly, and a one-cycle
//   done pulse is produced at terminal count. Auto-reload turns the block into
//   a periodic tick generator.
//
//   Optional feature macro: DOWN_CNT_PRESCALE_EN
//     When defined, an internal prescaler makes the decrement/terminal action
//     happen only on every PRESCALE-th enabled RUN cycle. When undefined the
//     PRESCALE parameter is ignored and the action happens on every enabled
//     cycle.
//
// Parameters
//   WIDTH       bit width of the count value and q
//   PRESCALE    enabled cycles per decrement (prescaler build only, >= 1)
//
// Ports
//   clk          in   rising-edge clock
//   reset        in   asynchronous active-low reset
//   load_valid   in   load_value is presented
//   load_ready   out  load can be accepted (IDLE/ARMED), low in RUN
//   load_value   in   initial / reload count
//   start        in   begin counting (sampled in ARMED only)
//   stop         in   abort counting (sampled in RUN only)
//   enable       in   count enable, gates decrement and terminal detection
//   auto_reload  in   at terminal count reload and keep running
//   q            out  current count
//   busy         out  high while in RUN
//   done         out  registered one-cycle pulse at terminal count
// -----------------------------------------------------------------------------
module down_counter_timer #(
  parameter int WIDTH    = 4,
  parameter int PRESCALE = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_value,
  input  logic             start,
  input  logic             stop,
  input  logic             enable,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_RUN   = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;
  logic             ready_q, ready_d;

  logic             load_fire_s;
  logic             run_en_s;
  logic             tick_s;
  logic             term_s;

  // load_ready is registered from the next state, so it already reflects
  // whether the current state may accept a load.
  assign load_fire_s = load_valid & ready_q;
  // stop has priority over any counting action in RUN.
  assign run_en_s    = (state_q == ST_RUN) & enable & ~stop;

`ifdef DOWN_CNT_PRESCALE_EN
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] presc_q, presc_d;

  // Action fires on the last prescaler step of an enabled RUN cycle.
  assign tick_s = run_en_s & (presc_q == PRESC_LAST);

  // Prescaler next value: cleared on load/start/stop and on every action.
  always_comb begin
    presc_d = presc_q;
    if (load_fire_s || ((state_q == ST_ARMED) && start) ||
        ((state_q == ST_RUN) && stop)) begin
      presc_d = {PW{1'b0}};
    end else if (run_en_s) begin
      if (tick_s) begin
        presc_d = {PW{1'b0}};
      end else begin
        presc_d = presc_q + PW'(1);
      end
    end else begin
      presc_d = presc_q;
    end
  end

  // Prescaler register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc_q <= {PW{1'b0}};
    end else begin
      presc_q <= presc_d;
    end
  end
`else
  assign tick_s = run_en_s;
`endif

  assign term_s = tick_s & (cnt_q == {WIDTH{1'b0}});

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        // start is ignored here; a load only arms the counter.
        if (load_fire_s) begin
          state_d = ST_ARMED;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ARMED: begin
        if (start) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_ARMED;
        end
      end
      ST_RUN: begin
        if (stop) begin
          state_d = ST_IDLE;
        end else if (term_s && !auto_reload) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Count / reload datapath and terminal pulse generation.
  always_comb begin
    cnt_d    = cnt_q;
    reload_d = reload_q;
    done_d   = 1'b0;
    if (load_fire_s) begin
      cnt_d    = load_value;
      reload_d = load_value;
    end else if (tick_s) begin
      if (term_s) begin
        done_d = 1'b1;
        if (auto_reload) begin
          cnt_d = reload_q;
        end else begin
          cnt_d = cnt_q;
        end
      end else begin
        cnt_d = cnt_q - {{(WIDTH-1){1'b0}}, 1'b1};
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Output decode from the next state so the registered outputs line up
  // with the state they describe.
  always_comb begin
    busy_d  = 1'b0;
    ready_d = 1'b1;
    if (state_d == ST_RUN) begin
      busy_d  = 1'b1;
      ready_d = 1'b0;
    end else begin
      busy_d  = 1'b0;
      ready_d = 1'b1;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q    <= {WIDTH{1'b0}};
      reload_q <= {WIDTH{1'b0}};
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      ready_q  <= 1'b1;
    end else begin
      cnt_q    <= cnt_d;
      reload_q <= reload_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
      ready_q  <= ready_d;
    end
  end

  assign q          = cnt_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign load_ready = ready_q;

endmodule

// File: tb/tb_down_counter_timer.sv
// -----------------------------------------------------------------------------
// tb_down_counter_timer
//   Self-checking bench: directed scenarios with hand-computed expectations
//   plus randomized stimulus, all compared every cycle against a behavioural
//   model of the timer kept in this file.
// -----------------------------------------------------------------------------
module tb_down_counter_timer;

  localparam int WIDTH    = 4;
  localparam int PRESCALE = 4;
`ifdef DOWN_CNT_PRESCALE_EN
  localparam int PS = PRESCALE;
`else
  localparam int PS = 1;
`endif

  localparam int M_IDLE  = 0;
  localparam int M_ARMED = 1;
  localparam int M_RUN   = 2;

  logic             clk;
  logic             rst_n;
  logic             load_valid;
  logic             load_ready;
  logic [WIDTH-1:0] load_value;
  logic             start;
  logic             stop;
  logic             enable;
  logic             auto_reload;
  logic [WIDTH-1:0] q;
  logic             busy;
  logic             done;

  int checks   = 0;
  int failures = 0;

  // Behavioural model state
  int m_mode;
  int m_q;
  int m_rel;
  int m_pc;
  bit m_done;

  down_counter_timer #(
    .WIDTH   (WIDTH),
    .PRESCALE(PRESCALE)
  ) dut (
    .clk        (clk),
    .reset      (rst_n),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_value (load_value),
    .start      (start),
    .stop       (stop),
    .enable     (enable),
    .auto_reload(auto_reload),
    .q          (q),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = M_IDLE;
    m_q    = 0;
    m_rel  = 0;
    m_pc   = 0;
    m_done = 1'b0;
  endtask

  // Apply one rising edge to the model using the inputs currently driven.
  task automatic model_edge();
    bit ld;
    bit nd;
    ld = load_valid && (m_mode != M_RUN);
    nd = 1'b0;
    if (m_mode == M_IDLE) begin
      if (ld) begin
        m_q = int'(load_value); m_rel = int'(load_value);
        m_mode = M_ARMED; m_pc = 0;
      end
    end else if (m_mode == M_ARMED) begin
      if (ld) begin
        m_q = int'(load_value); m_rel = int'(load_value); m_pc = 0;
      end
      if (start) begin
        m_mode = M_RUN; m_pc = 0;
      end
    end else begin
      if (stop) begin
        m_mode = M_IDLE; m_pc = 0;
      end else if (enable) begin
        if (m_pc == PS - 1) begin
          m_pc = 0;
          if (m_q == 0) begin
            nd = 1'b1;
            if (auto_reload) m_q = m_rel;
            else m_mode = M_IDLE;
          end else begin
            m_q = m_q - 1;
          end
        end else begin
          m_pc = m_pc + 1;
        end
      end
    end
    m_done = nd;
  endtask

  // Compare process: outputs against the model on every falling edge.
  always @(negedge clk) begin
    chk("q", int'(q), m_q);
    chk("busy", int'(busy), (m_mode == M_RUN) ? 1 : 0);
    chk("load_ready", int'(load_ready), (m_mode != M_RUN) ? 1 : 0);
    chk("done", int'(done), int'(m_done));
  end

  task automatic step(input bit lv, input int val, input bit st, input bit sp,
                      input bit en, input bit ar);
    @(negedge clk);
    load_valid  = lv;
    load_value  = val[WIDTH-1:0];
    start       = st;
    stop        = sp;
    enable      = en;
    auto_reload = ar;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle_inputs();
    load_valid = 1'b0; load_value = '0; start = 1'b0;
    stop = 1'b0; enable = 1'b0; auto_reload = 1'b0;
  endtask

  // Asynchronous reset pulse asserted between clock edges.
  task automatic do_reset(input bit pin);
    @(negedge clk);
    idle_inputs();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    if (pin) begin
      chk("rst_q", int'(q), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_ready", int'(load_ready), 1);
    end
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  initial begin
    idle_inputs();
    model_reset();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("init_q", int'(q), 0);
    chk("init_ready", int'(load_ready), 1);
    chk("init_busy", int'(busy), 0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    model_edge();
    #1;

    // Async reset mid-RUN at q=3
    step(1, 3, 0, 0, 0, 0);
    step(0, 0, 1, 0, 1, 0);
    chk("t1_q_before", int'(q), 3);
    chk("t1_busy_before", int'(busy), 1);
    do_reset(1'b1);
    chk("t1_idle_ready", int'(load_ready), 1);

`ifndef DOWN_CNT_PRESCALE_EN
    // Load 5, one-shot count down
    step(1, 5, 0, 0, 1, 0);
    chk("t2_armed_q", int'(q), 5);
    step(0, 0, 1, 0, 1, 0);
    chk("t2_start_q", int'(q), 5);
    for (int k = 1; k <= 5; k++) begin
      step(0, 0, 0, 0, 1, 0);
      chk("t2_q", int'(q), 5 - k);
      chk("t2_nodone", int'(done), 0);
    end
    step(0, 0, 0, 0, 1, 0);
    chk("t2_done", int'(done), 1);
    chk("t2_idle_busy", int'(busy), 0);
    chk("t2_q0", int'(q), 0);
    step(0, 0, 0, 0, 1, 0);
    chk("t2_done_once", int'(done), 0);

    // Load 2 with auto-reload
    step(1, 2, 0, 0, 1, 1);
    step(0, 0, 1, 0, 1, 1);
    for (int k = 0; k < 6; k++) begin
      step(0, 0, 0, 0, 1, 1);
      chk("t3_q", int'(q), (k % 3 == 0) ? 1 : ((k % 3 == 1) ? 0 : 2));
      chk("t3_done", int'(done), (k % 3 == 2) ? 1 : 0);
      chk("t3_busy", int'(busy), 1);
    end
    step(0, 0, 0, 1, 1, 1);

    // Load 3 with enable toggling; loads ignored in RUN
    step(1, 3, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    for (int k = 0; k < 7; k++) begin
      step((k % 2) == 1, 7, 0, 0, (k % 2) == 0, 0);
      chk("t4_ready", int'(load_ready), (k == 6) ? 1 : 0);
      chk("t4_done", int'(done), (k == 6) ? 1 : 0);
    end
    chk("t4_q", int'(q), 0);

    // Load 9, stop at q=2
    step(1, 9, 0, 0, 1, 0);
    step(0, 0, 1, 0, 1, 0);
    for (int k = 0; k < 7; k++) step(0, 0, 0, 0, 1, 0);
    chk("t5_q2", int'(q), 2);
    step(0, 0, 0, 1, 1, 0);
    chk("t5_stop_q", int'(q), 2);
    chk("t5_stop_busy", int'(busy), 0);
    chk("t5_stop_done", int'(done), 0);
    step(1, 1, 0, 0, 1, 0);
    chk("t5_reload_q", int'(q), 1);
    chk("t5_armed_ready", int'(load_ready), 1);

    // Load 0 and start on the same edge from ARMED
    step(1, 0, 1, 0, 1, 0);
    chk("t6_q", int'(q), 0);
    chk("t6_busy", int'(busy), 1);
    step(0, 0, 0, 0, 1, 0);
    chk("t6_done", int'(done), 1);
    chk("t6_idle", int'(busy), 0);
`else
    // Prescaled: load 1 gives done after 8 enabled cycles
    step(1, 1, 0, 0, 1, 0);
    step(0, 0, 1, 0, 1, 0);
    for (int k = 1; k <= 8; k++) begin
      step(0, 0, 0, 0, 1, 0);
      chk("p_done", int'(done), (k == 8) ? 1 : 0);
    end
`endif

    // Randomized traffic with occasional resets
    for (int n = 0; n < 3000; n++) begin
      if (($urandom % 600) == 0) begin
        do_reset(1'b0);
      end else begin
        step(($urandom % 10) < 3, int'($urandom % 16), ($urandom % 10) < 3,
             ($urandom % 40) == 0, ($urandom % 4) != 0, ($urandom % 2) == 1);
      end
    end

    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
